mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/y86_mem_pkg.sv | 34 +++
 rtl/instr_align.sv | 35 +++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86 memory arbiter and the memory stage:
// arbiter state encoding, transfer sizes and instruction codes.
package y86_mem_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    D_ISSUE  = 3'd1,
    D_DONE   = 3'd2,
    ERR_DONE = 3'd3,
    F_W0     = 3'd4,
    F_W1     = 3'd5,
    F_W2     = 3'd6,
    F_DONE   = 3'd7
  } arb_state_t;

  // Memory word size and the maximum Y86 instruction length, in bytes.
  localparam int WORD_BYTES  = 8;
  localparam int FETCH_BYTES = 10;

  // Y86-64 instruction codes (high nibble of the first instruction byte).
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/instr_align.sv
// Combinational byte extractor: picks OUT_BYTES consecutive bytes out of
// three little-endian memory words, starting at byte offset i_off.
module instr_align
  import y86_mem_pkg::*;
#(
  parameter int N         = 64,
  parameter int OUT_BYTES = FETCH_BYTES
) (
  input  logic [3*N-1:0]         i_words,
  input  logic [2:0]             i_off,
  output logic [8*OUT_BYTES-1:0] o_instr
);

  localparam int NB   = (3 * N) / 8;
  localparam int IDXW = $clog2(NB);

  logic [7:0] w_bytes [NB];

  genvar gi;

  // Split the concatenated words into an addressable byte array.
  generate
    for (gi = 0; gi < NB; gi++) begin : g_split
      assign w_bytes[gi] = i_words[8*gi +: 8];
    end
  endgenerate

  // Output byte k is input byte k + offset (byte at the fetch address lands in [7:0]).
  generate
    for (gi = 0; gi < OUT_BYTES; gi++) begin : g_pick
      assign o_instr[8*gi +: 8] = w_bytes[IDXW'(gi) + IDXW'(i_off)];
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port 64-bit memory between the instruction
// fetch port (10-byte unaligned fetches) and the data port (aligned words).
module mem_arbiter
  import y86_mem_pkg::*;
#(
  parameter int n         = 64,
  parameter int MEM_BYTES = 8192
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          f_req,
  input  logic [n-1:0]  f_addr,
  output logic          f_ack,
  output logic [79:0]   f_instr,
  output logic          f_err,
  // data port
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [n-1:0]  d_addr,
  input  logic [n-1:0]  d_wdata,
  output logic          d_ack,
  output logic [n-1:0]  d_rdata,
  output logic          d_err,
  // memory port
  output logic          mem_en,
  output logic          mem_wr,
  output logic [n-1:0]  mem_addr,
  output logic [n-1:0]  mem_wdata,
  input  logic [n-1:0]  mem_rdata
);

  arb_state_t   r_state;
  logic         r_last_data;   // 1 when the most recent grant went to data
  logic [2:0]   r_off;         // fetch byte offset within the first word
  logic [n-1:0] r_base;        // fetch address aligned down to a word
  logic [n-1:0] r_w0;
  logic [n-1:0] r_w1;
  logic         r_f_ack, r_f_err, r_d_ack, r_d_err;
  logic         r_mem_en, r_mem_wr;
  logic [n-1:0] r_mem_addr, r_mem_wdata;

  logic [n:0]   w_f_last;
  logic [n:0]   w_d_end;
  logic         w_f_bad;
  logic         w_d_bad;
  logic         w_grant_d;
  logic         w_grant_f;
  logic [n-1:0] w_f_base;
  logic [3*n-1:0] w_words;

  // Range checks in n+1 bits so that a wrap past 2^n reads as out of range.
  always_comb begin
    w_f_last = {1'b0, f_addr} + (n+1)'(FETCH_BYTES - 1);
    w_d_end  = {1'b0, d_addr} + (n+1)'(WORD_BYTES);
    w_f_bad  = (w_f_last >= (n+1)'(MEM_BYTES));
    w_d_bad  = (d_addr[2:0] != 3'd0) || (w_d_end > (n+1)'(MEM_BYTES));
    w_f_base = {f_addr[n-1:3], 3'b000};
  end

  // Alternating priority: data wins a tie unless it won the previous grant.
  always_comb begin
    w_grant_d = d_req && (!f_req || !r_last_data);
    w_grant_f = f_req && !w_grant_d;
  end

  // Transaction FSM; all handshake and memory command outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_data <= 1'b0;
      r_off       <= 3'd0;
      r_base      <= '0;
      r_w0        <= '0;
      r_w1        <= '0;
      r_f_ack     <= 1'b0;
      r_f_err     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_f_ack  <= 1'b0;
      r_f_err  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_d_err  <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_wr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_last_data <= 1'b1;
            if (w_d_bad) begin
              r_state <= ERR_DONE;
              r_d_ack <= 1'b1;
              r_d_err <= 1'b1;
            end else begin
              r_state     <= D_ISSUE;
              r_mem_en    <= 1'b1;
              r_mem_wr    <= d_wr;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
            end
          end else if (w_grant_f) begin
            r_last_data <= 1'b0;
            if (w_f_bad) begin
              r_state <= ERR_DONE;
              r_f_ack <= 1'b1;
              r_f_err <= 1'b1;
            end else begin
              r_state    <= F_W0;
              r_mem_en   <= 1'b1;
              r_mem_addr <= w_f_base;
              r_base     <= w_f_base;
              r_off      <= f_addr[2:0];
            end
          end
        end
        D_ISSUE: begin
          r_state <= D_DONE;
          r_d_ack <= 1'b1;
        end
        F_W0: begin
          r_state    <= F_W1;
          r_mem_en   <= 1'b1;
          r_mem_addr <= r_base + n'(WORD_BYTES);
        end
        F_W1: begin
          r_w0 <= mem_rdata;
          if (r_off == 3'd7) begin
            r_state    <= F_W2;
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_base + n'(2 * WORD_BYTES);
          end else begin
            r_state <= F_DONE;
            r_f_ack <= 1'b1;
          end
        end
        F_W2: begin
          r_w1    <= mem_rdata;
          r_state <= F_DONE;
          r_f_ack <= 1'b1;
        end
        D_DONE, ERR_DONE, F_DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The final word of a fetch is taken straight from the memory read bus.
  always_comb begin
    if (r_off == 3'd7) w_words = {mem_rdata, r_w1, r_w0};
    else               w_words = {{n{1'b0}}, mem_rdata, r_w0};
  end

  instr_align #(
    .N         (n),
    .OUT_BYTES (FETCH_BYTES)
  ) u_instr_align (
    .i_words (w_words),
    .i_off   (r_off),
    .o_instr (f_instr)
  );

  assign d_rdata   = mem_rdata;
  assign f_ack     = r_f_ack;
  assign f_err     = r_f_err;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural
// single-port memory (one-cycle registered read).
module tb_mem_arbiter;

  localparam int N  = 64;
  localparam int MB = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req;
  logic [N-1:0]  f_addr;
  logic          f_ack;
  logic [79:0]   f_instr;
  logic          f_err;
  logic          d_req;
  logic          d_wr;
  logic [N-1:0]  d_addr;
  logic [N-1:0]  d_wdata;
  logic          d_ack;
  logic [N-1:0]  d_rdata;
  logic          d_err;
  logic          mem_en;
  logic          mem_wr;
  logic [N-1:0]  mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] tb_mem [MB/8];

  mem_arbiter #(.n(N), .MEM_BYTES(MB)) dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_instr   (f_instr),
    .f_err     (f_err),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: loads bytes 0x00..0x17 with their own address during reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MB/8; k++) tb_mem[k] <= '0;
      tb_mem[0] <= 64'h0706050403020100;
      tb_mem[1] <= 64'h0F0E0D0C0B0A0908;
      tb_mem[2] <= 64'h1716151413121110;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_wr) tb_mem[mem_addr[12:3]] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr[12:3]];
    end
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Packs the handshake/command strobes {f_ack,f_err,d_ack,d_err,mem_en,mem_wr}.
  function automatic logic [79:0] strobes();
    return {74'd0, f_ack, f_err, d_ack, d_err, mem_en, mem_wr};
  endfunction

  initial begin
    reset = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0;
    step(); step();
    chk("reset_strobes", strobes(), 80'b000000);
    reset = 1'b0;
    step();
    chk("idle_strobes", strobes(), 80'b000000);

    // Data write 0x40
    d_req = 1'b1; d_wr = 1'b1; d_addr = 64'h40; d_wdata = 64'h1122334455667788;
    step();
    chk("wr_issue_strobes", strobes(), 80'b000011);
    chk("wr_issue_addr", mem_addr, 80'h40);
    chk("wr_issue_wdata", mem_wdata, 80'h1122334455667788);
    step();
    chk("wr_done_strobes", strobes(), 80'b001000);
    d_req = 1'b0; d_wr = 1'b0;
    step();
    chk("wr_after_strobes", strobes(), 80'b000000);

    // Data read 0x40
    d_req = 1'b1; d_addr = 64'h40;
    step();
    chk("rd_issue_strobes", strobes(), 80'b000010);
    step();
    chk("rd_done_strobes", strobes(), 80'b001000);
    chk("rd_data", d_rdata, 80'h1122334455667788);
    d_req = 1'b0;
    step();

    // Fetch 0x03: reads 0x00, 0x08; ack on third cycle
    f_req = 1'b1; f_addr = 64'h03;
    step();
    chk("f3_w0_addr", {mem_en, mem_addr}, {1'b1, 64'h00});
    step();
    chk("f3_w1_addr", {mem_en, mem_addr}, {1'b1, 64'h08});
    chk("f3_w1_noack", strobes(), 80'b000010);
    step();
    chk("f3_done_strobes", strobes(), 80'b100000);
    chk("f3_instr", f_instr, 80'h0C0B0A09080706050403);
    f_req = 1'b0;
    step();
    chk("f3_after", strobes(), 80'b000000);

    // Fetch 0x07: three reads, ack on fourth cycle
    f_req = 1'b1; f_addr = 64'h07;
    step();
    chk("f7_w0_addr", {mem_en, mem_addr}, {1'b1, 64'h00});
    step();
    chk("f7_w1_addr", {mem_en, mem_addr}, {1'b1, 64'h08});
    step();
    chk("f7_w2_addr", {mem_en, mem_addr}, {1'b1, 64'h10});
    chk("f7_w2_noack", f_ack, 80'd0);
    step();
    chk("f7_done_strobes", strobes(), 80'b100000);
    chk("f7_instr", f_instr, 80'h100F0E0D0C0B0A090807);
    f_req = 1'b0;
    step();

    // Contention with both held: D (misaligned -> error), F, D, F
    d_req = 1'b1; d_wr = 1'b0; d_addr = 64'h41;
    f_req = 1'b1; f_addr = 64'h03;
    step();
    chk("arb1_d_err", strobes(), 80'b001100);
    step();
    chk("arb2_idle", strobes(), 80'b000000);
    step();
    chk("arb3_f_w0", {mem_en, mem_addr}, {1'b1, 64'h00});
    step();
    chk("arb4_f_w1", {mem_en, mem_addr}, {1'b1, 64'h08});
    step();
    chk("arb5_f_done", strobes(), 80'b100000);
    chk("arb5_instr", f_instr, 80'h0C0B0A09080706050403);
    step();
    chk("arb6_idle", strobes(), 80'b000000);
    step();
    chk("arb7_d_err", strobes(), 80'b001100);
    d_req = 1'b0;
    step();
    step();
    chk("arb9_f_w0", {mem_en, mem_addr}, {1'b1, 64'h00});
    step();
    step();
    chk("arb11_f_done", strobes(), 80'b100000);
    f_req = 1'b0;
    step();

    // Reset during F_W1 abandons the fetch
    f_req = 1'b1; f_addr = 64'h03;
    step();
    step();
    chk("rst_in_fw1", {mem_en, mem_addr}, {1'b1, 64'h08});
    reset = 1'b1; f_req = 1'b0;
    step();
    chk("rst_strobes", strobes(), 80'b000000);
    reset = 1'b0;
    step();
    chk("rst_no_ack", strobes(), 80'b000000);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 64'h10;
    step();
    chk("post_rst_issue", {mem_en, mem_wr, mem_addr}, {2'b10, 64'h10});
    step();
    chk("post_rst_done", strobes(), 80'b001000);
    chk("post_rst_data", d_rdata, 80'h1716151413121110);
    d_req = 1'b0;
    step();

    // Fetch range boundary: last byte at MB-1 is fine, at MB is an error
    f_req = 1'b1; f_addr = 64'(MB - 9);
    step();
    chk("f_oob_err", strobes(), 80'b110000);
    f_req = 1'b0;
    step();
    f_req = 1'b1; f_addr = 64'(MB - 10);
    step();
    chk("f_edge_w0", {mem_en, mem_addr}, {1'b1, 64'(MB - 16)});
    step();
    step();
    chk("f_edge_done", strobes(), 80'b100000);
    f_req = 1'b0;
    step();
    f_req = 1'b1; f_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    chk("f_wrap_err", strobes(), 80'b110000);
    f_req = 1'b0;
    step();

    // Data range boundary: last word valid, one past it an error
    d_req = 1'b1; d_addr = 64'(MB - 8);
    step();
    chk("d_edge_issue", {mem_en, mem_addr}, {1'b1, 64'(MB - 8)});
    step();
    chk("d_edge_done", strobes(), 80'b001000);
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_addr = 64'(MB);
    step();
    chk("d_oob_err", strobes(), 80'b001100);
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_addr = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    chk("d_wrap_err", strobes(), 80'b001100);
    d_req = 1'b0;
    step();
    chk("final_idle", strobes(), 80'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
